lfsr_seq_ctrl: RTL and testbench

Sequencing controller for the 64-bit LFSR seed generator. It loads a user seed into the LFSR, runs a fixed warm-up, then advances the LFSR a programmable number of steps per request. Each resulting word is handed to the consumer, such as the board-initialisation logic, over a valid/ready handshake. The LFSR register itself stays external: this block drives its load/shift controls and reads back its state.

---
 rtl/lfsr_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - seed/warm-up/step sequencer for an external LFSR (optional macro: LFSR_SEQ_AUTOGEN_EN)
module lfsr_seq_ctrl #(
  parameter int unsigned      WIDTH        = 64,
  parameter int unsigned      WARMUP       = 16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [7:0]       steps,
  input  logic             gen_req,
  input  logic [WIDTH-1:0] lfsr_q,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_shift,
  output logic             rand_valid,
  output logic [WIDTH-1:0] rand_data,
  input  logic             rand_ready,
  output logic             seeded,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_READY,
    S_STEP,
    S_CAPT,
    S_OUT
  } state_t;

  localparam logic [7:0] WARMUP_CNT = 8'(WARMUP);

  state_t           state_q, state_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       steps_q, steps_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load_q, shift_q, valid_q, seeded_q, busy_q;
  logic [7:0]       steps_eff;

  // A request for zero shifts would hand back the previous word, so it is promoted to one.
  assign steps_eff = (steps == 8'd0) ? 8'd1 : steps;

  // Next-state logic: start preempts everything, otherwise walk load -> warm-up -> request/step/capture/output.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    steps_d = steps_q;
    seed_d  = seed_q;
    data_d  = data_q;
    if (start) begin
      state_d = S_LOAD;
      seed_d  = (seed_in == '0) ? DEFAULT_SEED : seed_in;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_LOAD: begin
          count_d = WARMUP_CNT;
          state_d = S_WARM;
        end
        S_WARM: begin
          count_d = count_q - 8'd1;
          if (count_q <= 8'd1) begin
            state_d = S_READY;
          end
        end
        S_READY: begin
          if (gen_req) begin
            steps_d = steps_eff;
            count_d = steps_eff;
            state_d = S_STEP;
          end
        end
        S_STEP: begin
          count_d = count_q - 8'd1;
          if (count_q <= 8'd1) begin
            state_d = S_CAPT;
          end
        end
        S_CAPT: begin
          data_d  = lfsr_q;
          state_d = S_OUT;
        end
        S_OUT: begin
          if (rand_ready) begin
`ifdef LFSR_SEQ_AUTOGEN_EN
            count_d = steps_q;
            state_d = S_STEP;
`else
            state_d = S_READY;
`endif
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and strobes; strobes are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= 8'd0;
      steps_q  <= 8'd1;
      seed_q   <= '0;
      data_q   <= '0;
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      valid_q  <= 1'b0;
      seeded_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      steps_q  <= steps_d;
      seed_q   <= seed_d;
      data_q   <= data_d;
      load_q   <= (state_d == S_LOAD);
      shift_q  <= (state_d == S_WARM) || (state_d == S_STEP);
      valid_q  <= (state_d == S_OUT);
      busy_q   <= (state_d == S_LOAD) || (state_d == S_WARM) ||
                  (state_d == S_STEP) || (state_d == S_CAPT);
      seeded_q <= (state_d == S_READY) || (seeded_q && !start);
    end
  end

  assign lfsr_load  = load_q;
  assign lfsr_seed  = seed_q;
  assign lfsr_shift = shift_q;
  assign rand_valid = valid_q;
  assign rand_data  = data_q;
  assign seeded     = seeded_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb/tb_lfsr_seq_ctrl.sv - randomized self-checking bench for lfsr_seq_ctrl with an external LFSR register
module tb_lfsr_seq_ctrl;

  localparam int          WU    = 16;
  localparam logic [63:0] DSEED = 64'h0000_0000_0000_0001;
  localparam logic [63:0] POLY  = 64'hD800_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset, start, gen_req, rand_ready;
  logic [63:0] seed_in, lfsr_reg, lfsr_seed, rand_data;
  logic [7:0]  steps;
  logic        lfsr_load, lfsr_shift, rand_valid, seeded, busy;

  int          n_run  = 0;
  int          n_fail = 0;
  logic [63:0] cur_raw, cur_seed;
  int          total;

  lfsr_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed_in    (seed_in),
    .steps      (steps),
    .gen_req    (gen_req),
    .lfsr_q     (lfsr_reg),
    .lfsr_load  (lfsr_load),
    .lfsr_seed  (lfsr_seed),
    .lfsr_shift (lfsr_shift),
    .rand_valid (rand_valid),
    .rand_data  (rand_data),
    .rand_ready (rand_ready),
    .seeded     (seeded),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // The LFSR register the controller sequences (Galois form, right shift).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_reg <= '0;
    else if (lfsr_load) lfsr_reg <= lfsr_seed;
    else if (lfsr_shift) lfsr_reg <= (lfsr_reg >> 1) ^ (lfsr_reg[0] ? POLY : 64'h0);
  end

  function automatic logic [63:0] lfsr_after(input logic [63:0] seed, input int n);
    logic [63:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    return s;
  endfunction

  task automatic test_reset();
    int bad = 0;
    reset = 1'b0; start = 1'b0; gen_req = 1'b0; rand_ready = 1'b0;
    seed_in = '0; steps = '0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({lfsr_load, lfsr_shift, rand_valid, seeded, busy} !== 5'b0 || lfsr_seed !== 64'h0 || rand_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_values: ctl=%b seed=%0h data=%0h, required all zero",
               {lfsr_load, lfsr_shift, rand_valid, seeded, busy}, lfsr_seed, rand_data);
    end
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if ({lfsr_load, lfsr_shift, rand_valid, seeded, busy} !== 5'b0) bad++;
    end
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: %0d active cycles, required 0", bad);
    end
  endtask

  // Called at a negedge: drives start now, checks the load/warm-up window, resets the model.
  task automatic do_reseed(input logic [63:0] seed);
    logic [63:0] exp_seed;
    int loads = 0, load_first = -1, shifts = 0, sh_first = -1, sh_last = -1;
    int seeded_first = -1, ctl_bad = 0, seed_bad = 0;
    exp_seed = (seed == 64'h0) ? DSEED : seed;
    start = 1'b1; seed_in = seed; gen_req = 1'b0;
    for (int c = 1; c <= WU + 4; c++) begin
      @(negedge clk);
      if (lfsr_load) begin loads++; if (load_first < 0) load_first = c; end
      if (lfsr_shift) begin shifts++; if (sh_first < 0) sh_first = c; sh_last = c; end
      if (seeded === 1'b1 && seeded_first < 0) seeded_first = c;
      if ((lfsr_load && lfsr_shift) || rand_valid !== 1'b0 || busy !== (c <= WU + 1)) ctl_bad++;
      if (c == 1 && lfsr_seed !== exp_seed) seed_bad++;
      if (c == 1) begin start = 1'b0; seed_in = {$urandom, $urandom}; end
    end
    n_run++;
    if (seed_bad != 0 || lfsr_seed !== exp_seed) begin
      n_fail++;
      $display("FAIL lfsr_seed: got %0h, required %0h", lfsr_seed, exp_seed);
    end
    n_run++;
    if (loads != 1 || load_first != 1) begin
      n_fail++;
      $display("FAIL load_pulse: %0d loads first at %0d, required 1 at cycle 1", loads, load_first);
    end
    n_run++;
    if (shifts != WU || sh_first != 2 || sh_last != WU + 1) begin
      n_fail++;
      $display("FAIL warmup_shifts: %0d shifts cycles %0d..%0d, required %0d cycles 2..%0d",
               shifts, sh_first, sh_last, WU, WU + 1);
    end
    n_run++;
    if (seeded_first != WU + 2) begin
      n_fail++;
      $display("FAIL seeded_time: first at cycle %0d, required %0d", seeded_first, WU + 2);
    end
    n_run++;
    if (ctl_bad != 0) begin
      n_fail++;
      $display("FAIL warmup_controls: %0d bad cycles (busy/valid/overlap), required 0", ctl_bad);
    end
    cur_raw = seed; cur_seed = exp_seed; total = 0;
  endtask

  // Called at a negedge in READY: requests one word and checks latency, shifts, data, hold and accept.
  task automatic do_gen(input int sv, input int ready_wait, output logic [63:0] word);
    int n, shifts = 0, sh_first = -1, sh_last = -1, loads = 0, valid_at = -1, hold_bad = 0;
    logic [63:0] exp_word;
    n = (sv == 0) ? 1 : sv;
    gen_req = 1'b1; steps = 8'(sv); rand_ready = (ready_wait == 0);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (lfsr_shift) begin shifts++; if (sh_first < 0) sh_first = c; sh_last = c; end
      if (lfsr_load) loads++;
      if (c == 1) begin gen_req = 1'b0; steps = 8'($urandom); end
      if (rand_valid) begin valid_at = c; break; end
    end
    total += n;
    exp_word = lfsr_after(cur_seed, WU + total);
    word = rand_data;
    n_run++;
    if (valid_at != n + 2) begin
      n_fail++;
      $display("FAIL gen_latency: rand_valid at cycle %0d, required %0d (steps=%0d)", valid_at, n + 2, sv);
    end
    n_run++;
    if (shifts != n || sh_first != 1 || sh_last != n || loads != 0) begin
      n_fail++;
      $display("FAIL gen_shifts: %0d shifts cycles %0d..%0d loads %0d, required %0d cycles 1..%0d loads 0",
               shifts, sh_first, sh_last, loads, n, n);
    end
    n_run++;
    if (rand_data !== exp_word) begin
      n_fail++;
      $display("FAIL gen_data: got %0h, required %0h (steps=%0d)", rand_data, exp_word, sv);
    end
    for (int k = 0; k < ready_wait; k++) begin
      gen_req = 1'($urandom); rand_ready = 1'b0;
      @(negedge clk);
      if (rand_valid !== 1'b1 || rand_data !== word || lfsr_shift || lfsr_load || seeded !== 1'b1) hold_bad++;
    end
    if (ready_wait > 0) begin
      n_run++;
      if (hold_bad != 0) begin
        n_fail++;
        $display("FAIL out_hold: %0d bad cycles over %0d, required 0", hold_bad, ready_wait);
      end
    end
    gen_req = 1'b0; rand_ready = 1'b1;
    @(negedge clk);
    rand_ready = 1'b0;
`ifdef LFSR_SEQ_AUTOGEN_EN
    n_run++;
    if (rand_valid !== 1'b0 || lfsr_shift !== 1'b1) begin
      n_fail++;
      $display("FAIL autogen_restep: valid=%b shift=%b, required valid=0 shift=1", rand_valid, lfsr_shift);
    end
    do_reseed(cur_raw);
`else
    hold_bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (rand_valid || lfsr_shift || lfsr_load || busy || seeded !== 1'b1) hold_bad++;
      @(negedge clk);
    end
    n_run++;
    if (hold_bad != 0) begin
      n_fail++;
      $display("FAIL accept_ready: %0d bad cycles after accept, required 0", hold_bad);
    end
`endif
  endtask

  task automatic test_seed();
    do_reseed(64'hACE1);
    do_reseed(64'h0);
  endtask

  task automatic test_gen_basic();
    logic [63:0] w;
    do_reseed(64'hACE1);
    do_gen(5, 0, w);
    do_gen(0, 0, w);
    do_gen(5, 8, w);
  endtask

  task automatic test_warm_ignore();
    logic [63:0] s;
    int found = 0, bad = 0;
    s = {$urandom, $urandom} | 64'h1;
    start = 1'b1; seed_in = s;
    @(negedge clk);
    start = 1'b0; gen_req = 1'b1;
    repeat (WU - 2) @(negedge clk);
    gen_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (seeded) begin found = 1; break; end
    end
    for (int k = 0; k < 5; k++) begin
      if (lfsr_shift || busy || rand_valid) bad++;
      @(negedge clk);
    end
    n_run++;
    if (found == 0 || bad != 0) begin
      n_fail++;
      $display("FAIL warm_gen_ignored: seeded=%0d activity=%0d, required seeded=1 activity=0", found, bad);
    end
    cur_raw = s; cur_seed = s; total = 0;
  endtask

  task automatic test_start_mid_step();
    logic [63:0] s, w1, w2;
    int shifts = 0, valids = 0;
    s = {$urandom, $urandom};
    do_reseed(s);
    do_gen(5, 0, w1);
    do_reseed(s);
    gen_req = 1'b1; steps = 8'd5; rand_ready = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      gen_req = 1'b0;
      if (lfsr_shift) shifts++;
      if (rand_valid) valids++;
    end
    n_run++;
    if (shifts != 2 || valids != 0) begin
      n_fail++;
      $display("FAIL mid_step_pre: shifts=%0d valids=%0d, required 2 and 0", shifts, valids);
    end
    do_reseed(s);
    do_gen(5, 0, w2);
    n_run++;
    if (w2 !== w1) begin
      n_fail++;
      $display("FAIL rerun_repeat: got %0h, required %0h", w2, w1);
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    gen_req = 1'b1; steps = 8'd20; rand_ready = 1'b0;
    @(negedge clk);
    gen_req = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_run++;
    if ({lfsr_load, lfsr_shift, rand_valid, seeded, busy} !== 5'b0 || lfsr_seed !== 64'h0 || rand_data !== 64'h0) begin
      n_fail++;
      $display("FAIL async_reset: ctl=%b seed=%0h data=%0h, required all zero",
               {lfsr_load, lfsr_shift, rand_valid, seeded, busy}, lfsr_seed, rand_data);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if ({lfsr_load, lfsr_shift, rand_valid, seeded, busy} !== 5'b0) bad++;
    end
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: %0d active cycles, required 0", bad);
    end
  endtask

`ifdef LFSR_SEQ_AUTOGEN_EN
  task automatic test_autogen();
    logic [63:0] s, w1, w2;
    int n, v1 = -1, v2 = -1, prev = 0;
    s = {$urandom, $urandom};
    do_reseed(s);
    n = $urandom_range(1, 6);
    gen_req = 1'b1; steps = 8'(n); rand_ready = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      gen_req = 1'b0;
      if (rand_valid && !prev) begin
        if (v1 < 0) begin v1 = c; w1 = rand_data; end
        else if (v2 < 0) begin v2 = c; w2 = rand_data; end
      end
      prev = rand_valid;
    end
    rand_ready = 1'b0;
    n_run++;
    if (v1 != n + 2 || v2 != 2 * (n + 2)) begin
      n_fail++;
      $display("FAIL autogen_timing: words at %0d,%0d, required %0d,%0d", v1, v2, n + 2, 2 * (n + 2));
    end
    n_run++;
    if (w1 !== lfsr_after(s == 0 ? DSEED : s, WU + n) || w2 !== lfsr_after(s == 0 ? DSEED : s, WU + 2 * n)) begin
      n_fail++;
      $display("FAIL autogen_data: got %0h,%0h, required %0h,%0h", w1, w2,
               lfsr_after(s == 0 ? DSEED : s, WU + n), lfsr_after(s == 0 ? DSEED : s, WU + 2 * n));
    end
    do_reseed(s);
  endtask
`endif

  task automatic test_random();
    logic [63:0] s, w;
    int sv, rw;
    for (int it = 0; it < 12; it++) begin
      if (it == 0 || $urandom_range(0, 2) == 0) begin
        s = ($urandom_range(0, 4) == 0) ? 64'h0 : {$urandom, $urandom};
        do_reseed(s);
      end
      case ($urandom_range(0, 4))
        0:       sv = 0;
        1:       sv = 1;
        2:       sv = 255;
        default: sv = $urandom_range(2, 40);
      endcase
      rw = $urandom_range(0, 8);
      do_gen(sv, rw, w);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_seed();
    test_gen_basic();
    test_warm_ignore();
    test_start_mid_step();
    test_async_reset();
`ifdef LFSR_SEQ_AUTOGEN_EN
    test_autogen();
`else
    do_reseed(64'h1234_5678_9ABC_DEF0);
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
